// File: rtl/dct2_2d_sched_if.sv
// Row-in / column-out handshake bundle for the 2-D DCT sequencer.
// The master drives rows and column back-pressure; the slave is the sequencer.
interface dct2_2d_sched_if #(
    parameter int SIZE_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [SIZE_W-1:0] in_size;
    logic              out_valid;
    logic              out_ready;
    logic              out_first;
    logic              out_last;

    modport master (
        output in_valid, in_size, out_ready,
        input  in_ready, out_valid, out_first, out_last
    );

    modport slave (
        input  in_valid, in_size, out_ready,
        output in_ready, out_valid, out_first, out_last
    );
endinterface

// File: rtl/dct2_2d_sched.sv
// Row-DCT / transpose / column-DCT sequencer with fill-drain overlap.
// Optional completed-block counter enabled by defining DCT2_BLK_CNT_EN.
module dct2_2d_sched #(
    parameter int SIZE_W    = 2,
    parameter int CNT_W     = 5,
    parameter int BLK_CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    dct2_2d_sched_if.slave    io,
    output logic              buf_en,
    output logic              buf_dir,
    output logic [SIZE_W-1:0] n_stage1,
    output logic [SIZE_W-1:0] n_stage2,
    output logic              busy
`ifdef DCT2_BLK_CNT_EN
    ,
    output logic [BLK_CNT_W-1:0] blk_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
    logic              ovl_q, ovl_d;
    logic              buf_dir_q, buf_dir_d;
    logic [SIZE_W-1:0] n1_q, n1_d;
    logic [SIZE_W-1:0] n2_q, n2_d;

    logic ovl_new, ovl_eff, row_last, col_last;
    logic in_ready, out_valid, shift;

    function automatic logic [CNT_W-1:0] last_idx(input logic [SIZE_W-1:0] code);
        return CNT_W'((32'd4 << code) - 32'd1);
    endfunction

    // Overlap is only ever decided on the first column of a drain.
    assign ovl_new  = (state_q == DRAIN) && !ovl_q && (col_cnt_q == '0)
                    && io.in_valid && (io.in_size == n2_q);
    assign ovl_eff  = ovl_q | ovl_new;
    assign row_last = (row_cnt_q == last_idx(n1_q));
    assign col_last = (col_cnt_q == last_idx(n2_q));

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        ovl_d     = ovl_q;
        buf_dir_d = buf_dir_q;
        n1_d      = n1_q;
        n2_d      = n2_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        shift     = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                shift    = io.in_valid;
                if (shift) begin
                    n1_d      = io.in_size;
                    row_cnt_d = CNT_W'(1);
                    state_d   = FILL;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                shift    = io.in_valid;
                if (shift) begin
                    if (row_last) begin
                        buf_dir_d = ~buf_dir_q;
                        n2_d      = n1_q;
                        col_cnt_d = '0;
                        ovl_d     = 1'b0;
                        state_d   = DRAIN;
                    end else begin
                        row_cnt_d = row_cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (ovl_eff) begin
                    out_valid = io.in_valid;
                    in_ready  = io.out_ready;
                    shift     = io.in_valid & io.out_ready;
                end else begin
                    out_valid = 1'b1;
                    shift     = io.out_ready;
                end
                if (shift) begin
                    col_cnt_d = col_cnt_q + CNT_W'(1);
                    if (ovl_new) begin
                        ovl_d = 1'b1;
                        n1_d  = io.in_size;
                    end
                    if (col_last) begin
                        col_cnt_d = '0;
                        if (ovl_q) begin
                            buf_dir_d = ~buf_dir_q;
                            n2_d      = n1_q;
                            ovl_d     = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            ovl_q     <= 1'b0;
            buf_dir_q <= 1'b0;
            n1_q      <= '0;
            n2_q      <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            ovl_q     <= ovl_d;
            buf_dir_q <= buf_dir_d;
            n1_q      <= n1_d;
            n2_q      <= n2_d;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid;
    assign io.out_first = out_valid & (col_cnt_q == '0);
    assign io.out_last  = out_valid & col_last;
    assign buf_en       = shift;
    assign buf_dir      = buf_dir_q;
    assign n_stage1     = n1_q;
    assign n_stage2     = n2_q;
    assign busy         = (state_q != IDLE);

`ifdef DCT2_BLK_CNT_EN
    logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (out_valid && io.out_ready && io.out_last)
            blk_cnt_d = blk_cnt_q + BLK_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) blk_cnt_q <= '0;
        else       blk_cnt_q <= blk_cnt_d;
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_dct2_2d_sched.sv
// Directed bench for dct2_2d_sched: cycle table for streamed blocks
// plus hand sequences for serial drain, stalls, size change and reset.
module tb_dct2_2d_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       buf_en, buf_dir, busy;
    logic [1:0] n_stage1, n_stage2;
`ifdef DCT2_BLK_CNT_EN
    logic [15:0] blk_cnt;
`endif

    int checks = 0;
    int errors = 0;

    dct2_2d_sched_if #(.SIZE_W(2)) io ();

    dct2_2d_sched dut (
        .clk      (clk),
        .reset    (reset),
        .io       (io),
        .buf_en   (buf_en),
        .buf_dir  (buf_dir),
        .n_stage1 (n_stage1),
        .n_stage2 (n_stage2),
        .busy     (busy)
`ifdef DCT2_BLK_CNT_EN
        ,
        .blk_cnt  (blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [1:0] sz;
        logic       ordy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [6:0] obs();
        return {io.in_ready, io.out_valid, io.out_first, io.out_last,
                buf_en, buf_dir, busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change at negedge; outputs are sampled 1 ns later.
    task automatic drive(input logic v, input logic [1:0] s, input logic r);
        @(negedge clk);
        io.in_valid  = v;
        io.in_size   = s;
        io.out_ready = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        io.in_valid  = 1'b0;
        io.in_size   = 2'd0;
        io.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic feed_rows(input int n, input logic [1:0] s);
        for (int i = 0; i < n; i++) drive(1'b1, s, 1'b1);
    endtask

    int beats, good;
    logic seen_last;

    initial begin
        reset        = 1'b1;
        io.in_valid  = 1'b0;
        io.in_size   = 2'd0;
        io.out_ready = 1'b1;

        // Three size-0 blocks back to back: {ir,ov,first,last,be,dir,busy}
        vecs[0]  = '{1'b1, 2'd0, 1'b1, 7'b1000100};
        vecs[1]  = '{1'b1, 2'd0, 1'b1, 7'b1000101};
        vecs[2]  = '{1'b1, 2'd0, 1'b1, 7'b1000101};
        vecs[3]  = '{1'b1, 2'd0, 1'b1, 7'b1000101};
        vecs[4]  = '{1'b1, 2'd0, 1'b1, 7'b1110111};
        vecs[5]  = '{1'b1, 2'd0, 1'b1, 7'b1100111};
        vecs[6]  = '{1'b1, 2'd0, 1'b1, 7'b1100111};
        vecs[7]  = '{1'b1, 2'd0, 1'b1, 7'b1101111};
        vecs[8]  = '{1'b1, 2'd0, 1'b1, 7'b1110101};
        vecs[9]  = '{1'b1, 2'd0, 1'b1, 7'b1100101};
        vecs[10] = '{1'b1, 2'd0, 1'b1, 7'b1100101};
        vecs[11] = '{1'b1, 2'd0, 1'b1, 7'b1101101};
        vecs[12] = '{1'b0, 2'd0, 1'b1, 7'b0110111};
        vecs[13] = '{1'b0, 2'd0, 1'b1, 7'b0100111};
        vecs[14] = '{1'b0, 2'd0, 1'b1, 7'b0100111};
        vecs[15] = '{1'b0, 2'd0, 1'b1, 7'b0101111};
        vecs[16] = '{1'b0, 2'd0, 1'b1, 7'b1000010};

        do_reset();
        #1;
        chk("reset_state", {obs(), n_stage1, n_stage2}, {7'b1000000, 4'b0000});

        // Streamed size-0 blocks with overlap
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].iv, vecs[i].sz, vecs[i].ordy);
            chk($sformatf("stream_c%0d", i), obs(), vecs[i].exp);
        end
`ifdef DCT2_BLK_CNT_EN
        chk("blk_cnt_3", blk_cnt, 32'd3);
        @(negedge clk);
        force dut.blk_cnt_q = 16'hFFFF;
        #1;
        release dut.blk_cnt_q;
        feed_rows(4, 2'd0);
        for (int i = 0; i < 5; i++) drive(1'b0, 2'd0, 1'b1);
        chk("blk_cnt_wrap", blk_cnt, 32'd0);
`endif

        // Size 1, serial drain
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 2'd1, 1'b1);
        chk("s1_row8_ready", {io.in_ready, busy, buf_dir}, 3'b110);
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 2'd1, 1'b1);
            chk($sformatf("s1_beat%0d", c),
                {io.out_valid, io.in_ready, io.out_first, io.out_last,
                 buf_en, buf_dir, n_stage2},
                {1'b1, 1'b0, (c == 0), (c == 7), 1'b1, 1'b1, 2'd1});
        end
        drive(1'b0, 2'd1, 1'b1);
        chk("s1_idle", {busy, buf_dir, io.out_valid, io.in_ready}, 4'b0101);

        // Size 3 drain with a size-0 row waiting
        do_reset();
        feed_rows(32, 2'd3);
        good = 0;
        for (int c = 0; c < 32; c++) begin
            drive(1'b1, 2'd0, 1'b1);
            if (io.out_valid && !io.in_ready && buf_en) good++;
        end
        chk("s3_drain_blocked", good, 32);
        drive(1'b1, 2'd0, 1'b1);
        chk("s3_idle_accept", {busy, io.in_ready, buf_en}, 3'b011);
        drive(1'b0, 2'd0, 1'b1);
        chk("s3_new_size", {busy, n_stage1, n_stage2}, {1'b1, 2'd0, 2'd3});

        // Size 2 drain with a 3-cycle stall at column 5
        do_reset();
        feed_rows(16, 2'd2);
        for (int c = 0; c < 5; c++) drive(1'b0, 2'd2, 1'b1);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 2'd2, 1'b0);
            chk($sformatf("s2_stall%0d", c),
                {io.out_valid, buf_en, io.out_first, io.out_last, buf_dir},
                5'b10001);
        end
        beats     = 0;
        seen_last = 1'b0;
        for (int c = 0; c < 40 && !seen_last; c++) begin
            drive(1'b0, 2'd2, 1'b1);
            if (io.out_valid && buf_en) beats++;
            if (io.out_first) beats += 100;
            if (io.out_last) seen_last = 1'b1;
        end
        chk("s2_remaining_beats", beats, 11);
        drive(1'b0, 2'd2, 1'b1);
        chk("s2_idle", {busy, buf_dir}, 2'b01);

        // Reset during fill of a size-2 block
        feed_rows(5, 2'd2);
        @(negedge clk);
        reset       = 1'b1;
        io.in_valid = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        io.in_valid = 1'b0;
        #1;
        chk("rst_mid_fill", {busy, buf_dir, io.in_ready, n_stage1}, {3'b001, 2'd0});
        feed_rows(4, 2'd0);
        beats     = 0;
        seen_last = 1'b0;
        drive(1'b0, 2'd0, 1'b1);
        chk("rst_fresh_first", {io.out_valid, io.out_first, buf_dir}, 3'b111);
        for (int c = 0; c < 10 && !seen_last; c++) begin
            if (io.out_valid && buf_en) beats++;
            if (io.out_last) seen_last = 1'b1;
            else drive(1'b0, 2'd0, 1'b1);
        end
        chk("rst_fresh_beats", beats, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
